// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the next-PC scheduler: pc_src codes, FSM states, exception vector.
package pc_ctrl_pkg;

  localparam logic [2:0]  PCSRC_SEQ  = 3'b000;
  localparam logic [2:0]  PCSRC_BR   = 3'b001;
  localparam logic [2:0]  PCSRC_J    = 3'b010;
  localparam logic [2:0]  PCSRC_JR   = 3'b011;
  localparam logic [2:0]  PCSRC_EXC  = 3'b100;

  localparam logic [31:0] EXC_VECTOR = 32'h8000_0004;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Counter width able to hold 0..maxv, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned maxv);
    return (maxv < 2) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl.sv
// Next-PC scheduler: picks one redirect source per cycle, drives PC/pipeline flush and hold
// controls combinationally, and tracks handler occupancy, EPC and load-use stall length.
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned MAX_STALL    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_req,
  input  logic [31:0] exc_pc,
  input  logic        branch_taken_ex,
  input  logic        jump_id,
  input  logic        jr_id,
  input  logic        eret_id,
  input  logic        load_use_hazard,
  output logic [2:0]  pc_src,
  output logic        pc_hold,
  output logic        pc_exception,
  output logic        jr_sel_epc,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
  output logic        hold_if_id,
  output logic [31:0] epc,
  output logic        in_handler,
  output logic        exc_dropped,
  output logic        stall_timeout
);

  localparam int unsigned DW = cnt_width(DRAIN_CYCLES);
  localparam int unsigned SW = cnt_width(MAX_STALL);

  state_e          state_q, state_d;
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [SW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [31:0]     epc_q, epc_d;
  logic            in_handler_q, in_handler_d;
  logic            stall_timeout_q, stall_timeout_d;
  logic            exc_dropped_q, exc_dropped_d;
  logic [SW-1:0]   stall_inc;

  assign epc           = epc_q;
  assign in_handler    = in_handler_q;
  assign exc_dropped   = exc_dropped_q;
  assign stall_timeout = stall_timeout_q;
  assign stall_inc     = stall_cnt_q + SW'(1);

  // Mealy decode: PC and pipeline registers consume these at the same edge.
  always_comb begin
    pc_src          = PCSRC_SEQ;
    pc_hold         = 1'b0;
    pc_exception    = 1'b0;
    jr_sel_epc      = 1'b0;
    flush_if_id     = 1'b0;
    flush_id_ex     = 1'b0;
    flush_ex_mem    = 1'b0;
    hold_if_id      = 1'b0;
    state_d         = state_q;
    drain_cnt_d     = drain_cnt_q;
    stall_cnt_d     = '0;
    epc_d           = epc_q;
    in_handler_d    = in_handler_q;
    stall_timeout_d = stall_timeout_q;
    exc_dropped_d   = 1'b0;

    if (rst_n) begin
      exc_dropped_d = exc_req & in_handler_q;
      case (state_q)
        ST_RUN: begin
          if (exc_req && !in_handler_q) begin
            pc_src       = PCSRC_EXC;
            pc_exception = 1'b1;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            epc_d        = exc_pc;
            in_handler_d = 1'b1;
            if (DRAIN_CYCLES != 0) begin
              drain_cnt_d = DW'(DRAIN_CYCLES);
              state_d     = ST_DRAIN;
            end
          end else if (branch_taken_ex) begin
            pc_src      = PCSRC_BR;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (load_use_hazard) begin
            pc_hold     = 1'b1;
            hold_if_id  = 1'b1;
            flush_id_ex = 1'b1;
            stall_cnt_d = (stall_cnt_q == SW'(MAX_STALL)) ? stall_cnt_q : stall_inc;
            if (stall_inc == SW'(MAX_STALL)) stall_timeout_d = 1'b1;
          end else if (eret_id && in_handler_q) begin
            pc_src       = PCSRC_JR;
            jr_sel_epc   = 1'b1;
            flush_if_id  = 1'b1;
            in_handler_d = 1'b0;
          end else if (jr_id) begin
            pc_src      = PCSRC_JR;
            flush_if_id = 1'b1;
          end else if (jump_id) begin
            pc_src      = PCSRC_J;
            flush_if_id = 1'b1;
          end
        end
        ST_DRAIN: begin
          // Stale younger-stage requests are ignored until the drain window expires.
          if (drain_cnt_q <= DW'(1)) begin
            drain_cnt_d = '0;
            state_d     = ST_RUN;
          end else begin
            drain_cnt_d = drain_cnt_q - DW'(1);
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_RUN;
      drain_cnt_q     <= '0;
      stall_cnt_q     <= '0;
      epc_q           <= '0;
      in_handler_q    <= 1'b0;
      stall_timeout_q <= 1'b0;
      exc_dropped_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      drain_cnt_q     <= drain_cnt_d;
      stall_cnt_q     <= stall_cnt_d;
      epc_q           <= epc_d;
      in_handler_q    <= in_handler_d;
      stall_timeout_q <= stall_timeout_d;
      exc_dropped_q   <= exc_dropped_d;
    end
  end

endmodule
